// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit: direct-mapped, one-word-per-frame instruction cache that
// answers datapath fetches and fills misses from memory control over the
// iREN/iwait handshake.
// Optional feature macro ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_fetch_unit #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag_mem  [SETS];
  logic [31:0]       r_data_mem [SETS];
  logic [31:0]       r_miss_addr;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_miss_idx;
  logic [TAG_W-1:0]  w_miss_tag;
  logic              w_lookup_hit;
  logic              w_miss_latch;
  logic              w_fill_we;

  // Address split for the live request and for the latched miss
  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = imemaddr[31:IDX_W+2];
  assign w_miss_idx = r_miss_addr[IDX_W+1:2];
  assign w_miss_tag = r_miss_addr[31:IDX_W+2];

  // Tag compare against the addressed frame
  assign w_lookup_hit = imemREN & r_valid[w_idx] & (r_tag_mem[w_idx] == w_tag);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and fetch/memory outputs
  always_comb begin
    w_next_state = r_state;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    iaddr        = '0;
    w_miss_latch = 1'b0;
    w_fill_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ihit     = w_lookup_hit;
        imemload = w_lookup_hit ? r_data_mem[w_idx] : 32'h0;
        if (imemREN && !w_lookup_hit) begin
          w_miss_latch = 1'b1;
          w_next_state = ST_FILL;
        end
      end
      ST_FILL: begin
        // Transaction always completes, even if the request is withdrawn
        iREN  = 1'b1;
        iaddr = r_miss_addr;
        if (!iwait) begin
          w_fill_we    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Latch the word-aligned miss address when leaving IDLE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_miss_addr <= '0;
    end else if (w_miss_latch) begin
      r_miss_addr <= imemaddr & 32'hFFFF_FFFC;
    end
  end

  // Valid bits; cleared on reset, set by a completed fill
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (w_fill_we) begin
      r_valid[w_miss_idx] <= 1'b1;
    end
  end

  // Tag/data storage; contents are don't-care until the valid bit is set
  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_tag_mem[w_miss_idx]  <= w_miss_tag;
      r_data_mem[w_miss_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Hit/miss event counters, wrapping modulo 2^32
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if ((r_state == ST_IDLE) && ihit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_latch) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed self-checking bench for icache_fetch_unit (SETS=16).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
module tb_icache_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int unsigned n_checks;
  int unsigned n_fails;

  icache_fetch_unit #(.SETS(16)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // 10-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic to_sample();
    @(negedge CLK);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Full miss sequence: IDLE miss cycle, nwait busy cycles, one fill cycle.
  // Returns at the start of the following IDLE cycle with the request held.
  task automatic do_miss(input string tag, input logic [31:0] addr,
                         input logic [31:0] data, input int nwait);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    to_sample();
    check({tag, "_miss_ihit"}, 32'(ihit), 32'h0);
    check({tag, "_miss_iren"}, 32'(iREN), 32'h0);
    next_cycle();
    for (int i = 0; i < nwait; i++) begin
      to_sample();
      check({tag, "_wait_iren"}, 32'(iREN), 32'h1);
      check({tag, "_wait_iaddr"}, iaddr, addr & 32'hFFFF_FFFC);
      check({tag, "_wait_ihit"}, 32'(ihit), 32'h0);
      next_cycle();
    end
    iwait = 1'b0;
    iload = data;
    to_sample();
    check({tag, "_fill_iren"}, 32'(iREN), 32'h1);
    check({tag, "_fill_iaddr"}, iaddr, addr & 32'hFFFF_FFFC);
    check({tag, "_fill_noforward"}, imemload, 32'h0);
    next_cycle();
    iwait = 1'b1;
    iload = 32'h0;
  endtask

  // One IDLE cycle expected to hit with the given word
  task automatic expect_hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
    imemREN  = 1'b1;
    imemaddr = addr;
    to_sample();
    check({tag, "_ihit"}, 32'(ihit), 32'h1);
    check({tag, "_imemload"}, imemload, data);
    check({tag, "_iren"}, 32'(iREN), 32'h0);
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;

    // Reset values
    #12;
    check("rst_iren", 32'(iREN), 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_ihit", 32'(ihit), 32'h0);
    check("rst_imemload", imemload, 32'h0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
`endif
    nRST = 1'b1;
    next_cycle();

    // Idle with no request: no hit, no memory traffic
    imemREN = 1'b0;
    imemaddr = 32'h40;
    to_sample();
    check("idle_ihit", 32'(ihit), 32'h0);
    check("idle_iren", 32'(iREN), 32'h0);
    next_cycle();

    // 1. Cold miss with two busy cycles, hit one cycle after the fill
    do_miss("cold", 32'h40, 32'h8C22_0004, 2);
    expect_hit("cold_post", 32'h40, 32'h8C22_0004);

    // 2. Warm hits, offset bits ignored
    expect_hit("warm40", 32'h40, 32'h8C22_0004);
    expect_hit("warm42", 32'h42, 32'h8C22_0004);

    // 3. Conflict in index 1: 0x04 and 0x44 evict each other
    do_miss("c04a", 32'h04, 32'h1111_1111, 0);
    expect_hit("c04a_hit", 32'h04, 32'h1111_1111);
    do_miss("c44", 32'h44, 32'h2222_2222, 1);
    expect_hit("c44_hit", 32'h44, 32'h2222_2222);
    do_miss("c04b", 32'h04, 32'h3333_3333, 0);
    expect_hit("c04b_hit", 32'h04, 32'h3333_3333);

    // 4. Request withdrawn and address changed while memory is busy
    imemREN  = 1'b1;
    imemaddr = 32'h80;
    iwait    = 1'b1;
    to_sample();
    check("abn_miss_ihit", 32'(ihit), 32'h0);
    next_cycle();
    imemREN  = 1'b0;
    imemaddr = 32'h100;
    for (int i = 0; i < 2; i++) begin
      to_sample();
      check("abn_wait_iren", 32'(iREN), 32'h1);
      check("abn_wait_iaddr", iaddr, 32'h80);
      next_cycle();
    end
    iwait = 1'b0;
    iload = 32'hDEAD_BEEF;
    to_sample();
    check("abn_fill_iaddr", iaddr, 32'h80);
    next_cycle();
    iwait = 1'b1;
    iload = 32'h0;
    to_sample();
    check("abn_idle_ihit", 32'(ihit), 32'h0);
    check("abn_idle_iren", 32'(iREN), 32'h0);
    next_cycle();
    expect_hit("abn_hit80", 32'h80, 32'hDEAD_BEEF);

    // 5. Asynchronous reset between edges during a fill
    imemREN  = 1'b1;
    imemaddr = 32'h200;
    iwait    = 1'b1;
    next_cycle();
    #1;
    check("rmf_fill_iren", 32'(iREN), 32'h1);
    nRST = 1'b0;
    #1;
    check("rmf_iren", 32'(iREN), 32'h0);
    check("rmf_iaddr", iaddr, 32'h0);
    check("rmf_ihit", 32'(ihit), 32'h0);
    imemREN = 1'b0;
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    next_cycle();
`ifdef ICACHE_STATS_EN
    check("rmf_hit_count", hit_count, 32'h0);
    check("rmf_miss_count", miss_count, 32'h0);
`endif

    // Previously cached 0x40 must miss after reset; then replay scenarios 1 and 2
    do_miss("rst40", 32'h40, 32'h8C22_0004, 2);
    expect_hit("rst40_post", 32'h40, 32'h8C22_0004);
    expect_hit("rst40_warm", 32'h40, 32'h8C22_0004);
    expect_hit("rst42_warm", 32'h42, 32'h8C22_0004);
    imemREN = 1'b0;
    to_sample();
    check("end_ihit", 32'(ihit), 32'h0);
`ifdef ICACHE_STATS_EN
    // 6. Counters after one miss and three hits
    check("stats_miss_count", miss_count, 32'd1);
    check("stats_hit_count", hit_count, 32'd3);
`endif
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time limit so the run can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_fetch_unit.md
Name: icache_fetch_unit

Overview:
- Instruction-side responder for the fetch path. Answers the program counter's fetch address with `imemload` and the `ihit` strobe that lets the PC advance.
- Direct-mapped, one-word-per-frame instruction cache.
- On a miss, a fill FSM fetches the word from memory control over the `iREN`/`iwait` handshake, writes the frame, then reports the hit.
- Sits between the datapath fetch stage and memory control.

Parameters:
SETS, 16, number of frames; power of two, 2..256
IDX_W, $clog2(SETS), index width (derived, not overridden)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
imemREN  input  1  fetch request from datapath
imemaddr  input  32  fetch byte address (word_t); bits [1:0] ignored
ihit  output  1  fetched word valid this cycle; PC advances on it
imemload  output  32  fetched instruction word
iREN  output  1  read request to memory control
iaddr  output  32  word-aligned read address to memory control
iwait  input  1  memory busy; low while iREN high means iload is valid
iload  input  32  read data from memory control

Behaviour:
- Interface: one clock `CLK`; reset `nRST` is asynchronous and active-low.
- Address split:
  - tag = `imemaddr[31:IDX_W+2]`
  - index = `imemaddr[IDX_W+1:2]`
  - offset [1:0] is dropped.
- Frame storage: `valid` (1), `tag` (30-IDX_W), `data` (32), per set.
- Reset, asserted asynchronously:
  - all valid bits = 0; state = IDLE; miss address register = 0.
  - outputs: `iREN`=0, `iaddr`=0, `ihit`=0, `imemload`=0.
  - tag/data contents are don't-care.
- States:
  - IDLE: combinational lookup.
    - hit = `imemREN` & valid[idx] & (tag[idx]==tag).
    - `ihit`=hit; `imemload` = hit ? data[idx] : 0; `iREN`=0.
    - If `imemREN` & !hit: latch `imemaddr` word-aligned into miss register; next state = FILL.
  - FILL: `iREN`=1, `iaddr` = miss register; `ihit`=0; `imemload`=0.
    - While `iwait`=1: hold; `iaddr` must not change.
    - First cycle with `iwait`=0: on the clock edge, write data=`iload`, tag, valid=1 into the latched set; next state = IDLE.
    - FILL does not sample `imemaddr`.
- Latency:
  - Hit: `ihit` in the same cycle as the request (0 cycles).
  - Miss: 1 cycle to enter FILL, N cycles of `iwait`, 1 fill cycle, then `ihit` in the following IDLE cycle. Minimum miss-to-hit is 3 cycles with `iwait` never high.
- No forwarding of `iload` to `imemload` during FILL.
- `imemREN` dropped mid-FILL: the fill still completes; the memory transaction is never aborted. Return to IDLE with no `ihit`.
- `imemaddr` changes mid-FILL: the latched address is filled; the new address is looked up in IDLE (may miss again).
- Conflict miss: a fill to an occupied set overwrites tag and data unconditionally.
- `imemREN`=0 in IDLE: `ihit`=0; no state change.
- Reset mid-FILL: `iREN` drops immediately; all frames become invalid.

Optional Feature:
- Macro: `ICACHE_STATS_EN`.
- When defined:
  - Adds outputs `hit_count` [31:0] and `miss_count` [31:0], both reset to 0.
  - `hit_count` increments on each IDLE cycle with `ihit`=1.
  - `miss_count` increments on each IDLE to FILL transition.
  - Both counters wrap modulo 2^32.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, `imemREN`=1, `imemaddr`=0x00000040; memory holds `iwait`=1 for 2 cycles, then `iload`=0x8C220004.
   - Required: `iREN`=1 with `iaddr`=0x40 for 3 cycles; `ihit`=1 with `imemload`=0x8C220004 exactly one cycle after the fill cycle.
2. Warm hit:
   - Stimulus: repeat a request to 0x40, and to 0x42 (offset ignored).
   - Required: `ihit`=1 in the same cycle, `imemload`=0x8C220004, `iREN` stays 0.
3. Conflict:
   - Stimulus: fill 0x00000004, then request 0x00000044 (same index 1, SETS=16), then 0x04 again.
   - Required: each request misses and refills; `iaddr` = 0x44, then 0x04.
4. Abandon mid-fill:
   - Stimulus: miss on 0x80; drop `imemREN` and change `imemaddr` to 0x100 while `iwait`=1.
   - Required: `iaddr` stays 0x80 until `iwait`=0; frame 0 (index of 0x80) becomes valid; a later request to 0x80 hits.
5. Reset mid-fill:
   - Stimulus: assert `nRST`=0 between clock edges during FILL.
   - Required: `iREN`=0 immediately; after release, a request to a previously cached address misses.
6. Stats (with `ICACHE_STATS_EN`):
   - Stimulus: run scenarios 1 and 2.
   - Required: `miss_count`=1, `hit_count`=3 (post-fill hit + 2 warm hits).
